// File: rtl/mips_mem_responder.sv
// mips_mem_responder: instruction/data memory model for a MIPS core.
// A streaming loader fills instruction memory while the CPU is held in
// reset (LOAD); the responder then serves fetches, loads and stores (RUN).
// Optional feature macro: MISALIGN_TRAP_EN (drop misaligned stores and
// raise the sticky misalign flag).
module mips_mem_responder #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_out,
    output logic [31:0] IR,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_rst,
    output logic [15:0] wr_count,
    output logic        misalign
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);
    localparam logic [IW-1:0] PTR_MAX = IW'(IMEM_WORDS - 1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [15:0]   wr_count_q, wr_count_d;
    logic          misalign_q, misalign_d;

    logic [31:0]   imem_q [IMEM_WORDS];
    logic [31:0]   dmem_q [DMEM_WORDS];

    logic [IW-1:0] pc_idx;
    logic [DW-1:0] da_idx;
    logic          pc_in_range;
    logic          da_in_range;
    logic          ld_fire;
    logic          store_ok;
    logic          unused_addr_bits;

    // Saturating 16-bit increment for the store counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Byte offsets are never used for word selection.
    assign unused_addr_bits = ^{pc_out[1:0], aluout[1:0]};

    assign pc_idx      = pc_out[IW+1:2];
    assign da_idx      = aluout[DW+1:2];
    assign pc_in_range = (pc_out[31:IW+2] == '0);
    assign da_in_range = (aluout[31:DW+2] == '0);

    assign ld_fire = (state_q == LOAD) && ld_valid;

`ifdef MISALIGN_TRAP_EN
    assign store_ok = (state_q == RUN) && memwrite && da_in_range && (aluout[1:0] == 2'b00);
`else
    assign store_ok = (state_q == RUN) && memwrite && da_in_range;
`endif

    // Next-state logic: loader pointer/state, store counter, sticky misalign flag.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_count_d = wr_count_q;
        misalign_d = misalign_q;

        if (ld_fire) begin
            if (ld_last || (ptr_q == PTR_MAX)) begin
                state_d = RUN;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end

        if (store_ok) begin
            wr_count_d = sat_inc16(wr_count_q);
        end

`ifdef MISALIGN_TRAP_EN
        if ((state_q == RUN) && memwrite && (aluout[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
`endif
    end

    // Control registers with asynchronous reset back to LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            ptr_q      <= '0;
            wr_count_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_count_q <= wr_count_d;
            misalign_q <= misalign_d;
        end
    end

    // Instruction memory write port, fed by the loader; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            imem_q[ptr_q] <= ld_data;
        end
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            dmem_q[da_idx] <= writedata;
        end
    end

    // Combinational read ports and state-derived handshake/hold outputs.
    always_comb begin
        IR       = 32'h0;
        readdata = 32'h0;
        if ((state_q == RUN) && pc_in_range) begin
            IR = imem_q[pc_idx];
        end
        if (da_in_range) begin
            readdata = dmem_q[da_idx];
        end
    end

    assign ld_ready = (state_q == LOAD);
    assign cpu_rst  = (state_q == LOAD);
    assign wr_count = wr_count_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: a behavioural memory model
// checked every cycle, plus literal expectations from hand-worked vectors.
module tb_mips_mem_responder;

    localparam int IMEM_WORDS = 64;
    localparam int DMEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_out = 32'h0;
    logic [31:0] IR;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'h0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_rst;
    logic [15:0] wr_count;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mem_responder #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .IR(IR),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .readdata(readdata), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .cpu_rst(cpu_rst),
        .wr_count(wr_count), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain arrays with "known" flags for words written so far.
    logic [31:0] m_imem [IMEM_WORDS];
    logic [31:0] m_dmem [DMEM_WORDS];
    bit          m_ik   [IMEM_WORDS];
    bit          m_dk   [DMEM_WORDS];
    bit          m_run;
    int          m_ptr;
    int          m_cnt;
    bit          m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0;
            m_ptr <= 0;
            m_cnt <= 0;
            m_mis <= 1'b0;
        end else begin
            if (!m_run && ld_valid) begin
                m_imem[m_ptr] <= ld_data;
                m_ik[m_ptr]   <= 1'b1;
                if (ld_last || m_ptr == IMEM_WORDS - 1) m_run <= 1'b1;
                else m_ptr <= m_ptr + 1;
            end
            if (m_run && memwrite) begin
`ifdef MISALIGN_TRAP_EN
                if (aluout[1:0] != 2'b00) m_mis <= 1'b1;
                else
`endif
                if (aluout < 32'(DMEM_WORDS * 4)) begin
                    m_dmem[aluout >> 2] <= writedata;
                    m_dk[aluout >> 2]   <= 1'b1;
                    m_cnt <= (m_cnt >= 16'hFFFF) ? m_cnt : m_cnt + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, !m_run});
        chk("cpu_rst", {31'b0, cpu_rst}, {31'b0, !m_run});
        chk("wr_count", {16'b0, wr_count}, 32'(m_cnt));
        chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
        if (!m_run || pc_out >= 32'(IMEM_WORDS * 4)) chk("ir_zero", IR, 32'h0);
        else if (m_ik[pc_out >> 2]) chk("ir", IR, m_imem[pc_out >> 2]);
        if (aluout >= 32'(DMEM_WORDS * 4)) chk("rd_zero", readdata, 32'h0);
        else if (m_dk[aluout >> 2]) chk("readdata", readdata, m_dmem[aluout >> 2]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'h1);
        chk("rst_cpu_rst", {31'b0, cpu_rst}, 32'h1);
        chk("rst_wr_count", {16'b0, wr_count}, 32'h0);
        chk("rst_ir", IR, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Load three words, last flagged on the third
        load_word(32'h20020005, 1'b0);
        load_word(32'h2003000c, 1'b0);
        chk("load_still_ready", {31'b0, ld_ready}, 32'h1);
        load_word(32'h2067fff7, 1'b1);
        chk("run_ld_ready", {31'b0, ld_ready}, 32'h0);
        chk("run_cpu_rst", {31'b0, cpu_rst}, 32'h0);
        pc_out = 32'h4;
        #1 chk("ir_pc4", IR, 32'h2003000c);
        pc_out = 32'h2;
        #1 chk("ir_pc2_ignored_bits", IR, 32'h20020005);
        pc_out = 32'h8;
        tick();

        // Store then load
        store(32'h54, 32'h7);
        chk("rd_54", readdata, 32'h7);
        chk("wr_count_1", {16'b0, wr_count}, 32'h1);
        aluout = 32'h57;
        #1 chk("rd_57_ignored_bits", readdata, 32'h7);

        // Out-of-range accesses
        pc_out = 32'h100;
        #1 chk("ir_oor", IR, 32'h0);
        pc_out = 32'hFC;
        store(32'h200, 32'h1234);
        chk("rd_oor", readdata, 32'h0);
        chk("wr_count_oor", {16'b0, wr_count}, 32'h1);

        // Misaligned store
        store(32'h55, 32'h9);
        aluout = 32'h54;
`ifdef MISALIGN_TRAP_EN
        #1 chk("misalign_rd", readdata, 32'h7);
        chk("misalign_flag", {31'b0, misalign}, 32'h1);
        chk("misalign_cnt", {16'b0, wr_count}, 32'h1);
`else
        #1 chk("misalign_rd", readdata, 32'h9);
        chk("misalign_flag", {31'b0, misalign}, 32'h0);
        chk("misalign_cnt", {16'b0, wr_count}, 32'h2);
`endif
        tick();

        // Loader pulses in RUN are ignored
        load_word(32'hDEADBEEF, 1'b0);
        load_word(32'hDEADBEEF, 1'b1);
        pc_out = 32'h0;
        #1 chk("ir_run_loader_ignored", IR, 32'h20020005);
        tick();

        // Reset mid-load, store during LOAD dropped
        do_reset();
        load_word(32'h11111111, 1'b0);
        load_word(32'h22222222, 1'b0);
        store(32'h10, 32'h55);
        chk("load_store_dropped", {16'b0, wr_count}, 32'h0);
        do_reset();
        load_word(32'hAAAA0000, 1'b1);
        pc_out = 32'h0;
        #1 chk("ir_after_reload", IR, 32'hAAAA0000);
        chk("reload_run", {31'b0, cpu_rst}, 32'h0);
        pc_out = 32'h4;
        #1 chk("ir_imem1_kept", IR, 32'h22222222);
        tick();

        // Fill the whole instruction memory without ld_last
        do_reset();
        for (int i = 0; i < IMEM_WORDS; i++) begin
            if (i == IMEM_WORDS - 1) chk("overflow_still_load", {31'b0, cpu_rst}, 32'h1);
            load_word(32'h10000000 + 32'(i), 1'b0);
        end
        chk("overflow_run", {31'b0, cpu_rst}, 32'h0);
        pc_out = 32'hFC;
        #1 chk("ir_last_word", IR, 32'h1000003F);
        pc_out = 32'h0;
        #1 chk("ir_first_word", IR, 32'h10000000);
        load_word(32'hBADBAD00, 1'b0);
        #1 chk("ir_no_wrap", IR, 32'h10000000);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
